// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// default widths/constants used by the interface and the controller.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          DEF_ADDR_W    = 32;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFC00_0000;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch sequencer (master) and memory/pipeline (slave).
// With IFETCH_PERF_EN defined the bus also carries the fetch/stall counters.
interface imem_fetch_ctrl_if
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              stall_i;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              resume_i;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              halted;
`ifdef IFETCH_PERF_EN
    logic [31:0]       fetch_count;
    logic [31:0]       stall_count;
`endif

    modport master (
        output imem_addr, instr_out, pc_out, instr_valid, halted,
`ifdef IFETCH_PERF_EN
        output fetch_count, stall_count,
`endif
        input  imem_instr, stall_i, redirect_valid, redirect_pc, resume_i
    );

    modport slave (
        input  imem_addr, instr_out, pc_out, instr_valid, halted,
`ifdef IFETCH_PERF_EN
        input  fetch_count, stall_count,
`endif
        output imem_instr, stall_i, redirect_valid, redirect_pc, resume_i
    );

endinterface

// File: rtl/imem_boot_timer.sv
// Boot-window down-counter: o_done rises once BOOT_CYCLES-1 enabled cycles
// have elapsed since reset, and stays high until the next reset.
module imem_boot_timer
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_done
);

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= CW'(BOOT_CYCLES - 1);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency instruction memory: boot wait, streaming,
// stall replay, redirect and halt/resume. IFETCH_PERF_EN adds fetch/stall counters.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                BOOT_CYCLES = 2,
    parameter logic [31:0]       HALT_WORD   = DEF_HALT_WORD
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic [31:0]       r_instr_out;
    logic [ADDR_W-1:0] r_pc_out;
    logic              r_instr_valid;
    logic              r_halted;
    logic              w_boot_done;

    imem_boot_timer #(.BOOT_CYCLES(BOOT_CYCLES)) u_boot_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == ST_BOOT),
        .o_done (w_boot_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_imem_addr   <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_instr_out   <= '0;
            r_pc_out      <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (w_boot_done) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        r_fetch_pc    <= bus.redirect_pc;
                        r_imem_addr   <= bus.redirect_pc;
                        r_inflight    <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end else if (bus.stall_i) begin
                        // Word returning now is dropped; refetch it once the stall clears.
                        if (r_inflight) begin
                            r_fetch_pc  <= r_inflight_pc;
                            r_imem_addr <= r_inflight_pc;
                            r_inflight  <= 1'b0;
                        end
                    end else begin
                        r_instr_valid <= r_inflight;
                        if (r_inflight) begin
                            r_instr_out <= bus.imem_instr;
                            r_pc_out    <= r_inflight_pc;
                        end
                        if (r_inflight && (bus.imem_instr == HALT_WORD)) begin
                            r_state     <= ST_HALT;
                            r_halted    <= 1'b1;
                            r_inflight  <= 1'b0;
                            r_fetch_pc  <= r_inflight_pc + PC_ONE;
                            r_imem_addr <= r_inflight_pc + PC_ONE;
                        end else begin
                            r_fetch_pc    <= r_fetch_pc + PC_ONE;
                            r_imem_addr   <= r_fetch_pc + PC_ONE;
                            r_inflight_pc <= r_fetch_pc;
                            r_inflight    <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    r_instr_valid <= 1'b0;
                    // imem_addr stays frozen while halted and is reloaded on resume.
                    if (bus.resume_i) begin
                        r_state     <= ST_RUN;
                        r_halted    <= 1'b0;
                        r_fetch_pc  <= bus.redirect_valid ? bus.redirect_pc : r_fetch_pc;
                        r_imem_addr <= bus.redirect_valid ? bus.redirect_pc : r_fetch_pc;
                    end else if (bus.redirect_valid) begin
                        r_fetch_pc <= bus.redirect_pc;
                    end
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign bus.imem_addr   = r_imem_addr;
    assign bus.instr_out   = r_instr_out;
    assign bus.pc_out      = r_pc_out;
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;

`ifdef IFETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        w_deliver;
    logic        w_run_stall;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign w_deliver   = (r_state == ST_RUN) && !bus.redirect_valid && !bus.stall_i && r_inflight;
    assign w_run_stall = (r_state == ST_RUN) && bus.stall_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_deliver)   r_fetch_count <= sat_inc(r_fetch_count);
            if (w_run_stall) r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign bus.fetch_count = r_fetch_count;
    assign bus.stall_count = r_stall_count;
`endif

endmodule
